// File: rtl/idex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module      : idex_pipeline_register
// Description : ID/EX pipeline register for the mips32 five-stage core with
//               integrated load-use hazard detection. Captures decoded
//               operands/control from ID, inserts a bubble on flush or
//               load-use stall, and keeps saturating stall/bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
module idex_pipeline_register #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_alu_src,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [DATA_W-1:0]  id_imm,
    output logic               stall,
    output logic               idex_valid,
    output logic [4:0]         idex_rs,
    output logic [4:0]         idex_rt,
    output logic [4:0]         idex_rd,
    output logic               idex_reg_write,
    output logic               idex_mem_to_reg,
    output logic               idex_mem_read,
    output logic               idex_mem_write,
    output logic               idex_alu_src,
    output logic [ALUOP_W-1:0] idex_alu_op,
    output logic [DATA_W-1:0]  idex_rdata1,
    output logic [DATA_W-1:0]  idex_rdata2,
    output logic [DATA_W-1:0]  idex_imm,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   bubble_count
);

    // Registered EX-stage state
    logic               r_valid;
    logic [4:0]         r_rs;
    logic [4:0]         r_rt;
    logic [4:0]         r_rd;
    logic               r_regWrite;
    logic               r_memToReg;
    logic               r_memRead;
    logic               r_memWrite;
    logic               r_aluSrc;
    logic [ALUOP_W-1:0] r_aluOp;
    logic [DATA_W-1:0]  r_rdata1;
    logic [DATA_W-1:0]  r_rdata2;
    logic [DATA_W-1:0]  r_imm;
    logic [CNT_W-1:0]   r_stallCount;
    logic [CNT_W-1:0]   r_bubbleCount;

    logic w_rsHit;
    logic w_rtHit;
    logic w_loadUse;
    logic w_stall;
    logic w_bubble;

    // Load-use detection. A store whose only dependence on the load is its
    // store data (rt) is resolved by the MEM/WB-to-MEM forward, so it does
    // not stall; a store using the load result as its base address does.
    always_comb begin
        w_rsHit   = id_uses_rs & (id_rs == r_rd);
        w_rtHit   = id_uses_rt & (id_rt == r_rd) & ~(id_mem_write & ~w_rsHit);
        w_loadUse = r_valid & r_memRead & r_regWrite & (r_rd != 5'd0)
                  & id_valid & (w_rsHit | w_rtHit);
        w_stall   = w_loadUse & ~flush & ~hold;
        w_bubble  = ~hold & (flush | w_loadUse);
    end

    // Pipeline register: hold freezes, flush/stall load an all-zero bubble,
    // otherwise capture the ID-stage instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rd       <= 5'd0;
            r_regWrite <= 1'b0;
            r_memToReg <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_aluSrc   <= 1'b0;
            r_aluOp    <= '0;
            r_rdata1   <= '0;
            r_rdata2   <= '0;
            r_imm      <= '0;
        end else if (hold) begin
            r_valid    <= r_valid;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rd       <= 5'd0;
            r_regWrite <= 1'b0;
            r_memToReg <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_aluSrc   <= 1'b0;
            r_aluOp    <= '0;
            r_rdata1   <= '0;
            r_rdata2   <= '0;
            r_imm      <= '0;
        end else begin
            r_valid    <= id_valid;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rd       <= id_rd;
            r_regWrite <= id_reg_write;
            r_memToReg <= id_mem_to_reg;
            r_memRead  <= id_mem_read;
            r_memWrite <= id_mem_write;
            r_aluSrc   <= id_alu_src;
            r_aluOp    <= id_alu_op;
            r_rdata1   <= id_rdata1;
            r_rdata2   <= id_rdata2;
            r_imm      <= id_imm;
        end
    end

    // Saturating stall counter: counts only stalls that actually took effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != {CNT_W{1'b1}})) begin
            r_stallCount <= r_stallCount + 1'b1;
        end
    end

    // Saturating bubble counter: every bubble load, from flush or stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubbleCount <= '0;
        end else if (w_bubble && (r_bubbleCount != {CNT_W{1'b1}})) begin
            r_bubbleCount <= r_bubbleCount + 1'b1;
        end
    end

    assign stall           = w_stall;
    assign idex_valid      = r_valid;
    assign idex_rs         = r_rs;
    assign idex_rt         = r_rt;
    assign idex_rd         = r_rd;
    assign idex_reg_write  = r_regWrite;
    assign idex_mem_to_reg = r_memToReg;
    assign idex_mem_read   = r_memRead;
    assign idex_mem_write  = r_memWrite;
    assign idex_alu_src    = r_aluSrc;
    assign idex_alu_op     = r_aluOp;
    assign idex_rdata1     = r_rdata1;
    assign idex_rdata2     = r_rdata2;
    assign idex_imm        = r_imm;
    assign stall_count     = r_stallCount;
    assign bubble_count    = r_bubbleCount;

endmodule
`default_nettype wire

// File: tb/tb_idex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_idex_pipeline_register
// Description : Directed self-checking bench for idex_pipeline_register.
//               Counters are built 8 bits wide so saturation is reachable
//               in a short run (a stall costs two cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idex_pipeline_register;

    localparam int DATA_W  = 32;
    localparam int ALUOP_W = 4;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n, hold, flush;
    logic               id_valid;
    logic [4:0]         id_rs, id_rt, id_rd;
    logic               id_uses_rs, id_uses_rt;
    logic               id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src;
    logic [ALUOP_W-1:0] id_alu_op;
    logic [DATA_W-1:0]  id_rdata1, id_rdata2, id_imm;
    logic               stall, idex_valid;
    logic [4:0]         idex_rs, idex_rt, idex_rd;
    logic               idex_reg_write, idex_mem_to_reg, idex_mem_read, idex_mem_write, idex_alu_src;
    logic [ALUOP_W-1:0] idex_alu_op;
    logic [DATA_W-1:0]  idex_rdata1, idex_rdata2, idex_imm;
    logic [CNT_W-1:0]   stall_count, bubble_count;

    int errors = 0;
    int checks = 0;

    idex_pipeline_register #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .stall(stall), .idex_valid(idex_valid),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_reg_write(idex_reg_write), .idex_mem_to_reg(idex_mem_to_reg),
        .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
        .idex_alu_src(idex_alu_src), .idex_alu_op(idex_alu_op),
        .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2), .idex_imm(idex_imm),
        .stall_count(stall_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic urs, input logic urt,
                         input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic asrc, input logic [3:0] op,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
        id_reg_write = rw; id_mem_to_reg = m2r; id_mem_read = mr; id_mem_write = mw;
        id_alu_src = asrc; id_alu_op = op;
        id_rdata1 = d1; id_rdata2 = d2; id_imm = im;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // lw $8,0($9)
    task automatic lw8();
        drive(1, 5'd9, 5'd8, 5'd8, 1, 0, 1, 1, 1, 0, 1, 4'd2, 32'h1000, 32'h0, 32'h0);
    endtask

    // add $10,$8,$3
    task automatic add10();
        drive(1, 5'd8, 5'd3, 5'd10, 1, 1, 1, 0, 0, 0, 0, 4'd2, 32'hAAAA, 32'h3, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
        // Reset with random ID inputs
        drive($urandom_range(0, 1), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), 4'($urandom), $urandom, $urandom, $urandom);
        tick(); tick();
        chk("rst_valid", idex_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_fields", {idex_rs, idex_rt, idex_rd, idex_reg_write, idex_mem_to_reg,
                           idex_mem_read, idex_mem_write, idex_alu_src, idex_alu_op}, 0);
        chk("rst_data", idex_rdata1 | idex_rdata2 | idex_imm, 0);
        chk("rst_cnt", {stall_count, bubble_count}, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_stall", stall, 0);
        idle();
        tick();
        chk("idle_valid", idex_valid, 0);

        // Load-use on rs
        lw8();
        chk("lu_c1_stall", stall, 0);
        tick();
        add10();
        chk("lu_c2_rd", idex_rd, 8);
        chk("lu_c2_memrd", idex_mem_read, 1);
        chk("lu_c2_stall", stall, 1);
        tick();
        chk("lu_c3_valid", idex_valid, 0);
        chk("lu_c3_bubble", {idex_rs, idex_rt, idex_rd, idex_reg_write, idex_mem_read, idex_alu_op}, 0);
        chk("lu_c3_data", idex_rdata1 | idex_rdata2 | idex_imm, 0);
        chk("lu_c3_stall", stall, 0);
        chk("lu_scnt", stall_count, 1);
        chk("lu_bcnt", bubble_count, 1);
        tick();
        chk("lu_c4_valid", idex_valid, 1);
        chk("lu_c4_regs", {idex_rs, idex_rt, idex_rd}, {5'd8, 5'd3, 5'd10});
        chk("lu_c4_d1", idex_rdata1, 32'hAAAA);
        chk("lu_c4_rw", idex_reg_write, 1);
        idle();

        // Store-data exception: sw $8,4($9)
        lw8();
        tick();
        drive(1, 5'd9, 5'd8, 5'd0, 1, 1, 0, 0, 0, 1, 1, 4'd2, 32'h2000, 32'h55, 32'h4);
        chk("sw_data_stall", stall, 0);
        tick();
        chk("sw_valid", idex_valid, 1);
        chk("sw_mw", idex_mem_write, 1);
        chk("sw_rt_imm", {idex_rt, idex_imm}, {5'd8, 32'h4});
        // sw $5,0($8): base from the load -> stall
        lw8();
        tick();
        drive(1, 5'd8, 5'd5, 5'd0, 1, 1, 0, 0, 0, 1, 1, 4'd2, 32'h0, 32'h77, 32'h0);
        chk("sw_base_stall", stall, 1);
        tick();
        chk("sw_base_bub", idex_valid, 0);
        chk("sw_scnt", stall_count, 2);
        chk("sw_bcnt", bubble_count, 2);
        idle();
        tick();

        // Zero register: lw $0 then add $1,$0,$0
        drive(1, 5'd9, 5'd0, 5'd0, 1, 0, 1, 1, 1, 0, 1, 4'd2, 32'h0, 32'h0, 32'h0);
        tick();
        drive(1, 5'd0, 5'd0, 5'd1, 1, 1, 1, 0, 0, 0, 0, 4'd2, 32'h0, 32'h0, 32'h0);
        chk("zero_stall", stall, 0);
        tick();
        chk("zero_cap", {idex_valid, idex_rd}, {1'b1, 5'd1});

        // Flush beats load-use
        lw8();
        tick();
        add10();
        flush = 1'b1;
        #1;
        chk("fl_stall", stall, 0);
        tick();
        flush = 1'b0;
        chk("fl_valid", idex_valid, 0);
        chk("fl_rd", idex_rd, 0);
        chk("fl_bcnt", bubble_count, 3);
        chk("fl_scnt", stall_count, 2);

        // Hold during a pending hazard
        lw8();
        tick();
        add10();
        hold = 1'b1;
        #1;
        chk("hold_stall", stall, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_frz", {idex_valid, idex_rd, idex_mem_read, idex_rs}, {1'b1, 5'd8, 1'b1, 5'd9});
            chk("hold_cnt", {stall_count, bubble_count}, {8'd2, 8'd3});
            chk("hold_st", stall, 0);
        end
        hold = 1'b0;
        #1;
        chk("unhold_stall", stall, 1);
        tick();
        chk("unhold_bub", idex_valid, 0);
        chk("unhold_cnt", {stall_count, bubble_count}, {8'd3, 8'd4});
        tick();
        chk("unhold_cap", {idex_valid, idex_rs, idex_rd}, {1'b1, 5'd8, 5'd10});

        // Reset asserted during a stall
        lw8();
        tick();
        add10();
        chk("mr_stall", stall, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_clear", {idex_valid, idex_rd, idex_mem_read}, 0);
        chk("mr_cnt", {stall_count, bubble_count}, 0);
        chk("mr_st", stall, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_rel_st", stall, 0);

        // Saturation: lw $8,0($8) repeated stalls every other cycle
        drive(1, 5'd8, 5'd0, 5'd8, 1, 0, 1, 1, 1, 0, 1, 4'd2, 32'h0, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 20; i++) tick();
        chk("sat_mid", stall_count, 10);
        for (int i = 0; i < 2 * 260; i++) tick();
        chk("sat_scnt", stall_count, 8'hFF);
        chk("sat_bcnt", bubble_count, 8'hFF);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
